// File: rtl/pcsequencer_pkg.sv
// Shared definitions for the instruction sequencer: FSM state encoding,
// HALT bit position and default geometry.
package proc_seq_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } seq_state_e;

  localparam int HALT_BIT      = 31;
  localparam int DEF_PCW       = 8;
  localparam int DEF_FETCH_TMO = 15;

endpackage

// File: rtl/pcsequencer_wdog.sv
// 4-bit fetch-timeout counter: counts enabled cycles, saturates at LIMIT,
// and flags expiry while the count sits at LIMIT.
module seq_wdog #(
  parameter logic [3:0] LIMIT = 4'd15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expired
);

  logic [3:0] count;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 4'd1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/pcsequencer.sv
// Instruction sequencer: owns the PC, fetches words over a req/valid
// handshake and presents each to the decoder for one execute cycle.
module pcsequencer
  import proc_seq_defs::*;
#(
  parameter int             PCW       = DEF_PCW,
  parameter logic [PCW-1:0] RESET_PC  = '0,
  parameter int             FETCH_TMO = DEF_FETCH_TMO
) (
  input  logic           iCLK,
  input  logic           iRST_N,
  input  logic           iRUN,
  input  logic           iSTEP,
  input  logic           iHALT,
  output logic           oIREQ,
  output logic [PCW-1:0] oIADDR,
  input  logic           iIVALID,
  input  logic [31:0]    iIDATA,
  output logic [31:0]    oINST,
  output logic           oEXEN,
  input  logic           iPCJEN,
  input  logic [PCW-1:0] iJTGT,
  output logic [PCW-1:0] oPC,
  output logic           oHALTED,
  output logic           oFAULT
);

  seq_state_e     state;
  logic [PCW-1:0] pc;
  logic [31:0]    inst;
  logic           step_flag;
  logic           halt_latch;
  logic           fault;
  logic           tmo_expired;

  // The counter only runs while a fetch is outstanding; any other state or
  // a completed handshake returns it to zero for the next fetch.
  seq_wdog #(
    .LIMIT (4'(FETCH_TMO))
  ) u_fetch_wdog (
    .clk     (iCLK),
    .rst_n   (iRST_N),
    .en      (state == FETCH),
    .clr     ((state != FETCH) || iIVALID),
    .expired (tmo_expired)
  );

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      inst       <= '0;
      step_flag  <= 1'b0;
      halt_latch <= 1'b0;
      fault      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iRUN || iSTEP) begin
            state      <= FETCH;
            step_flag  <= !iRUN;
            halt_latch <= 1'b0;
            fault      <= 1'b0;
          end
        end
        FETCH: begin
          if (iHALT) halt_latch <= 1'b1;
          if (iIVALID) begin
            inst  <= iIDATA;
            state <= EXEC;
          end else if (tmo_expired) begin
            fault <= 1'b1;
            state <= IDLE;
          end
        end
        EXEC: begin
          pc <= iPCJEN ? iJTGT : pc + PCW'(1);
          if (step_flag || halt_latch || iHALT || inst[HALT_BIT]) state <= IDLE;
          else                                                     state <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode straight from the state register, so they are glitch-free
  // and drop the moment reset asserts, without depending on any input.
  assign oIREQ   = (state == FETCH);
  assign oEXEN   = (state == EXEC);
  assign oHALTED = (state == IDLE);
  assign oIADDR  = pc;
  assign oPC     = pc;
  assign oINST   = inst;
  assign oFAULT  = fault;

endmodule
